ram1_ctrl: RTL and testbench
============================

// Module: ram1_ctrl
// PURPOSE
//  Sequential controller between the MEM-stage data port and the ram1 word SRAM.
//  Accepts one CPU byte-addressed request at a time and maps it to a word address.
//  Sequences ce/re/we over WAIT_CYCLES-cycle SRAM accesses and merges byte lanes by read-modify-write.
//  Returns read data with a one-cycle ack and raises stall_req to freeze the pipeline meanwhile.
// PARAMETERS
//  WAIT_CYCLES  1     cycles each SRAM read or write phase is held (>=1)
//  DEPTH        4096  words in ram1; used only by the address check
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst          in   1   asynchronous active-low reset
//  cpu_req      in   1   request; held high until cpu_ack
//  cpu_we       in   1   1=write, 0=read
//  cpu_addr     in   32  byte address; [1:0] ignored
//  cpu_sel      in   4   byte enables; sel[0]=bits 7:0 ... sel[3]=bits 31:24
//  cpu_wdata    in   32  lane-aligned write data
//  cpu_rdata    out  32  read word, valid while cpu_ack=1
//  cpu_ack      out  1   one-cycle completion pulse
//  cpu_err      out  1   one-cycle error pulse alongside cpu_ack (RAM1_ADDR_CHECK_EN only)
//  stall_req    out  1   cpu_req & ~cpu_ack (combinational)
//  mem_ce       out  1   chip enable to ram1
//  mem_re       out  1   read enable to ram1
//  mem_we       out  1   write enable to ram1
//  mem_addr     out  32  word address {2'b00, cpu_addr[31:2]} from latched request
//  mem_wdata    out  32  write data to ram1
//  mem_rdata    in   32  read data from ram1 (combinational, same cycle)
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE; cpu_rdata, mem_addr, mem_wdata, counter = 0;
//   cpu_ack, cpu_err, mem_ce, mem_re, mem_we deasserted (defines.v disable values).
//  Reset mid-transaction: abort immediately, no ack; any partial RMW write is lost.
//  States: IDLE, RD, RMW_RD, WR, DONE. Enables: ce+re in RD/RMW_RD, ce+we in WR, else all off.
//  IDLE: when cpu_req=1, latch addr/we/sel/wdata, counter=0, then:
//   cpu_we=0 -> RD; cpu_we=1 & sel=4'b1111 -> WR (mem_wdata=cpu_wdata);
//   cpu_we=1 & sel partial -> RMW_RD; sel=4'b0000 -> DONE (no RAM access).
//  RD/RMW_RD/WR: held WAIT_CYCLES cycles, counter counts 0..WAIT_CYCLES-1.
//   RD last cycle: cpu_rdata<=mem_rdata -> DONE.
//   RMW_RD last cycle: mem_wdata<=per lane sel ? wdata lane : mem_rdata lane -> WR.
//   WR last cycle -> DONE.
//  DONE: cpu_ack=1 one cycle -> IDLE. cpu_rdata holds until next read completes.
//  Latency (cpu_req sampled to ack): read / full write WAIT_CYCLES+1;
//   partial write 2*WAIT_CYCLES+1; sel=0 write 1.
//  Latched inputs: changes to cpu_* after IDLE are ignored until DONE.
//  Back-to-back: cpu_req still high in IDLE after DONE starts a new transaction.
//  Never asserts mem_re and mem_we together; WR follows RMW_RD with no idle cycle.
// CONFIGURATION
//  RAM1_ADDR_CHECK_EN defined: in IDLE, if cpu_addr[31:2] >= DEPTH, go to DONE with no
//   RAM access; DONE pulses cpu_ack and cpu_err; cpu_rdata loaded with 0.
//  Undefined: no check; cpu_err tied 0; out-of-range addresses pass through, ram1 wraps on [11:0].
// TESTING
//  Reset: rst=0 mid-run -> all outputs 0/disabled same cycle, state IDLE.
//  Read: ram[4]=0xDEADBEEF, req addr 0x10 we=0 sel=F, WAIT=1 -> mem_addr=4 with ce+re 1 cycle;
//   ack 2 cycles after req, cpu_rdata=0xDEADBEEF.
//  Full write: addr 0x20 wdata 0x12345678 sel=F -> one WR cycle with mem_addr=8;
//   ack at +2; readback gives 0x12345678.
//  RMW: ram[2]=0xAABBCCDD, write addr 0x8 sel=0011 wdata 0x11223344 -> RMW_RD then WR;
//   ram[2]=0xAABB3344, ack at +3 (WAIT=1) / +5 (WAIT=2).
//  Back-to-back: two reads held req -> acks at +2 and +5, stall_req low only on ack cycles.
//  RAM1_ADDR_CHECK_EN: read addr 0x00004000 -> no ce, ack+err at +1, rdata=0;
//   without the macro, mem_addr=0x1000 and ram1 returns ram[0].

Source files
------------

// File: rtl/ram1_ctrl.sv
// ram1_ctrl: sequential bridge between the MEM-stage data port and the ram1 word SRAM.
// Optional RAM1_ADDR_CHECK_EN: reject word addresses >= DEPTH with cpu_err instead of wrapping.
module ram1_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned DEPTH       = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_sel,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic        stall_req,
    output logic        mem_ce,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [29:0]       addr_q, addr_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              last_cycle;
    logic              addr_bad;

    // Byte offset bits and DEPTH are not needed for every build.
    logic unused_ok;
    assign unused_ok = ^cpu_addr[1:0] ^ (DEPTH == 0);

    assign last_cycle = (cnt_q == CNT_LAST);

`ifdef RAM1_ADDR_CHECK_EN
    logic err_q, err_d;
    assign addr_bad = ({2'b00, cpu_addr[31:2]} >= 32'(DEPTH));
    assign cpu_err  = (state_q == DONE) && err_q;
`else
    assign addr_bad = 1'b0;
    assign cpu_err  = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments only; next-state logic lives in
    // always_comb so that every flop updates from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            sel_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_wdata_q <= '0;
`ifdef RAM1_ADDR_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef RAM1_ADDR_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    // NOTE: every signal written here gets a hold/default value first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mem_wdata_d = mem_wdata_q;
`ifdef RAM1_ADDR_CHECK_EN
        err_d       = err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr[31:2];
                    sel_d   = cpu_sel;
                    wdata_d = cpu_wdata;
                    cnt_d   = '0;
`ifdef RAM1_ADDR_CHECK_EN
                    err_d   = addr_bad;
`endif
                    if (addr_bad) begin
                        rdata_d = '0;
                        state_d = DONE;
                    end else if (!cpu_we) begin
                        state_d = RD;
                    end else if (cpu_sel == 4'b1111) begin
                        mem_wdata_d = cpu_wdata;
                        state_d     = WR;
                    end else if (cpu_sel == 4'b0000) begin
                        state_d = DONE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end

            RD: begin
                if (last_cycle) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RMW_RD: begin
                if (last_cycle) begin
                    // Merge: enabled lanes take the new data, the rest keep the SRAM word.
                    for (int i = 0; i < 4; i++) begin
                        mem_wdata_d[i*8 +: 8] = sel_q[i] ? wdata_q[i*8 +: 8]
                                                         : mem_rdata[i*8 +: 8];
                    end
                    cnt_d   = '0;
                    state_d = WR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WR: begin
                if (last_cycle) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_ce = 1'b0;
        mem_re = 1'b0;
        mem_we = 1'b0;
        case (state_q)
            RD, RMW_RD: begin
                mem_ce = 1'b1;
                mem_re = 1'b1;
            end
            WR: begin
                mem_ce = 1'b1;
                mem_we = 1'b1;
            end
            default: ;
        endcase
    end

    assign cpu_ack   = (state_q == DONE);
    assign stall_req = cpu_req & ~cpu_ack;
    assign cpu_rdata = rdata_q;
    assign mem_addr  = {2'b00, addr_q};
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ram1_ctrl.sv
// Self-checking bench for ram1_ctrl: table of single transactions plus sequences for
// latched inputs, back-to-back requests, mid-transaction reset and WAIT_CYCLES=2 RMW.
module tb_ram1_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_req2 = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [3:0]  cpu_sel = '0;
    logic [31:0] cpu_wdata = '0;

    logic [31:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ack, cpu_err, stall_req, mem_ce, mem_re, mem_we;
    logic [31:0] cpu_rdata2, mem_addr2, mem_wdata2, mem_rdata2;
    logic        cpu_ack2, cpu_err2, stall_req2, mem_ce2, mem_re2, mem_we2;

    logic [31:0] ram  [0:4095];
    logic [31:0] ram2 [0:4095];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ram1_ctrl #(.WAIT_CYCLES(1), .DEPTH(4096)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_sel(cpu_sel),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .stall_req(stall_req), .mem_ce(mem_ce), .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    ram1_ctrl #(.WAIT_CYCLES(2), .DEPTH(4096)) u_dut2 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req2), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_sel(cpu_sel),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata2), .cpu_ack(cpu_ack2), .cpu_err(cpu_err2),
        .stall_req(stall_req2), .mem_ce(mem_ce2), .mem_re(mem_re2), .mem_we(mem_we2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
    );

    // SRAM models: combinational read, write on the rising edge, wrap on [11:0].
    assign mem_rdata  = ram[mem_addr[11:0]];
    assign mem_rdata2 = ram2[mem_addr2[11:0]];
    always @(posedge clk) if (mem_ce && mem_we) ram[mem_addr[11:0]] <= mem_wdata;
    always @(posedge clk) if (mem_ce2 && mem_we2) ram2[mem_addr2[11:0]] <= mem_wdata2;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic        exp_err;
        logic [31:0] exp_maddr;
        logic [11:0] chk_idx;
        logic [31:0] chk_word;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input string n, input logic we, input logic [31:0] addr,
                                input logic [3:0] sel, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input int lat, input int rd,
                                input int wr, input logic err, input logic [31:0] maddr,
                                input logic [11:0] idx, input logic [31:0] word);
        vec_t v;
        v.name = n; v.we = we; v.addr = addr; v.sel = sel; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wr;
        v.exp_err = err; v.exp_maddr = maddr; v.chk_idx = idx; v.chk_word = word;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int   lat = 0;
        int   rd_n = 0;
        int   wr_n = 0;
        bit   got = 0;
        bit   maddr_ok = 1;
        bit   stall_ok = 1;
        bit   excl_ok = 1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_sel = v.sel; cpu_wdata = v.wdata;
        while (!got && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (mem_ce && mem_re) rd_n++;
            if (mem_ce && mem_we) wr_n++;
            if (mem_re && mem_we) excl_ok = 0;
            if (mem_ce && (mem_addr !== v.exp_maddr)) maddr_ok = 0;
            if (stall_req !== ~cpu_ack) stall_ok = 0;
            if (cpu_ack) got = 1;
        end
        check($sformatf("%s_ack_seen", v.name), 32'(got), 32'd1);
        check($sformatf("%s_lat", v.name), 32'(lat), 32'(v.exp_lat));
        check($sformatf("%s_rdata", v.name), cpu_rdata, v.exp_rdata);
        check($sformatf("%s_err", v.name), 32'(cpu_err), 32'(v.exp_err));
        check($sformatf("%s_rd_cycles", v.name), 32'(rd_n), 32'(v.exp_rd));
        check($sformatf("%s_wr_cycles", v.name), 32'(wr_n), 32'(v.exp_wr));
        check($sformatf("%s_mem_addr", v.name), 32'(maddr_ok), 32'd1);
        check($sformatf("%s_stall", v.name), 32'(stall_ok), 32'd1);
        check($sformatf("%s_re_we_excl", v.name), 32'(excl_ok), 32'd1);
        check($sformatf("%s_ram_word", v.name), ram[v.chk_idx], v.chk_word);
        cpu_req = 1'b0;
        @(negedge clk);
        check($sformatf("%s_ack_pulse", v.name), 32'(cpu_ack), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ack_vec;
        logic [4:0] stall_vec;
        int         lat2;
        int         rd2;
        int         wr2;

        for (int i = 0; i < 4096; i++) begin
            ram[i] = '0;
            ram2[i] = '0;
        end
        ram[0] = 32'hCAFEF00D;
        ram[2] = 32'hAABBCCDD;
        ram[3] = 32'h01020304;
        ram[4] = 32'hDEADBEEF;
        ram[5] = 32'h11111111;
        ram2[2] = 32'hAABBCCDD;

        //            name     we   addr          sel      wdata          rdata          lat rd wr err maddr  idx     word
        vecs[0] = mk("rd4",    0, 32'h10,       4'hF, 32'h0,        32'hDEADBEEF, 2, 1, 0, 0, 32'h4, 12'h4, 32'hDEADBEEF);
        vecs[1] = mk("wr8",    1, 32'h20,       4'hF, 32'h12345678, 32'hDEADBEEF, 2, 0, 1, 0, 32'h8, 12'h8, 32'h12345678);
        vecs[2] = mk("rd8",    0, 32'h20,       4'hF, 32'h0,        32'h12345678, 2, 1, 0, 0, 32'h8, 12'h8, 32'h12345678);
        vecs[3] = mk("rmw_lo", 1, 32'h8,        4'h3, 32'h11223344, 32'h12345678, 3, 1, 1, 0, 32'h2, 12'h2, 32'hAABB3344);
        vecs[4] = mk("rd2",    0, 32'h8,        4'hF, 32'h0,        32'hAABB3344, 2, 1, 0, 0, 32'h2, 12'h2, 32'hAABB3344);
        vecs[5] = mk("rmw_hi", 1, 32'h8,        4'h8, 32'h55000000, 32'hAABB3344, 3, 1, 1, 0, 32'h2, 12'h2, 32'h55BB3344);
        vecs[6] = mk("sel0",   1, 32'h8,        4'h0, 32'hFFFFFFFF, 32'hAABB3344, 1, 0, 0, 0, 32'h2, 12'h2, 32'h55BB3344);
        vecs[7] = mk("rmw_mid",1, 32'hC,        4'h6, 32'h00ABCD00, 32'hAABB3344, 3, 1, 1, 0, 32'h3, 12'h3, 32'h01ABCD04);
        vecs[8] = mk("rd_off", 0, 32'hE,        4'hF, 32'h0,        32'h01ABCD04, 2, 1, 0, 0, 32'h3, 12'h3, 32'h01ABCD04);
`ifdef RAM1_ADDR_CHECK_EN
        vecs[9] = mk("rd_oor", 0, 32'h00004000, 4'hF, 32'h0,        32'h0,        1, 0, 0, 1, 32'h1000, 12'h0, 32'hCAFEF00D);
`else
        vecs[9] = mk("rd_oor", 0, 32'h00004000, 4'hF, 32'h0,        32'hCAFEF00D, 2, 1, 0, 0, 32'h1000, 12'h0, 32'hCAFEF00D);
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ctrl", {26'd0, cpu_ack, cpu_err, mem_ce, mem_re, mem_we, stall_req}, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_txn(vecs[i]);

        // Inputs changed after IDLE must not affect the running read
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_sel = 4'hF; cpu_wdata = '0;
        @(posedge clk); @(negedge clk);
        cpu_addr = 32'h20; cpu_we = 1'b1; cpu_sel = 4'h0; cpu_wdata = 32'h0;
        @(posedge clk); @(negedge clk);
        check("latch_ack", 32'(cpu_ack), 32'd1);
        check("latch_rdata", cpu_rdata, 32'hDEADBEEF);
        cpu_req = 1'b0;
        @(negedge clk);
        check("latch_ram8", ram[8], 32'h12345678);

        // Back-to-back reads with req held: acks at +2 and +5
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_sel = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); @(negedge clk);
            ack_vec[c]   = cpu_ack;
            stall_vec[c] = stall_req;
        end
        cpu_req = 1'b0;
        check("b2b_acks", 32'(ack_vec), 32'b10010);
        check("b2b_stall", 32'(stall_vec), 32'b01101);
        check("b2b_rdata", cpu_rdata, 32'hDEADBEEF);
        @(negedge clk);

        // Reset during RMW: abort at once, partial write lost
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h14; cpu_sel = 4'h1; cpu_wdata = 32'hAA;
        @(posedge clk); @(negedge clk);
        check("mid_in_rmw_rd", {29'd0, mem_ce, mem_re, mem_we}, 32'b110);
        rst = 1'b0;
        #1;
        check("mid_rst_ctrl", {27'd0, cpu_ack, cpu_err, mem_ce, mem_re, mem_we}, 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        check("mid_rst_rdata", cpu_rdata, 32'd0);
        check("mid_rst_wdata", mem_wdata, 32'd0);
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_ram5", ram[5], 32'h11111111);
        check("mid_rst_idle", {30'd0, mem_ce, cpu_ack}, 32'd0);

        // WAIT_CYCLES=2 partial write: ack at +5
        @(negedge clk);
        cpu_req2 = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h8; cpu_sel = 4'h3; cpu_wdata = 32'h11223344;
        lat2 = 0; rd2 = 0; wr2 = 0;
        while (!cpu_ack2 && lat2 < 20) begin
            @(posedge clk); @(negedge clk);
            lat2++;
            if (mem_ce2 && mem_re2) rd2++;
            if (mem_ce2 && mem_we2) wr2++;
        end
        cpu_req2 = 1'b0;
        check("w2_lat", 32'(lat2), 32'd5);
        check("w2_rd_cycles", 32'(rd2), 32'd2);
        check("w2_wr_cycles", 32'(wr2), 32'd2);
        check("w2_ram2", ram2[2], 32'hAABB3344);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
